// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB bus bundle for apb_slave_mem; pstrb present only with APB_SLV_PSTRB_EN
interface apb_slave_mem_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
`ifdef APB_SLV_PSTRB_EN
   logic [DATA_W/8-1:0] pstrb;
`endif
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
`ifdef APB_SLV_PSTRB_EN
      output pstrb,
`endif
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
`ifdef APB_SLV_PSTRB_EN
      input  pstrb,
`endif
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave word memory with wait states and error response; byte strobes with APB_SLV_PSTRB_EN
module apb_slave_mem #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 1
) (
   input logic              pclk,
   input logic              prst,
   apb_slave_mem_if.slave   bus
);
   localparam int NBYTES = DATA_W / 8;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W  = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                pwrite_q;
   logic                err_q;
   logic [IDX_W-1:0]    idx_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [NBYTES-1:0]   strb_q;
   logic [DATA_W-1:0]   rd_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                setup;
   logic                complete;
   logic                commit;
   logic [ADDR_W-1:0]   word_a;
   logic                addr_err;
   logic [NBYTES-1:0]   strb_in;

   // Address decode: upper address bits take part in the range check so nothing aliases
   assign word_a   = bus.paddr / ADDR_W'(NBYTES);
   assign addr_err = ((bus.paddr % ADDR_W'(NBYTES)) != '0) || (word_a >= ADDR_W'(DEPTH));
`ifdef APB_SLV_PSTRB_EN
   assign strb_in  = bus.pstrb;
`else
   assign strb_in  = '1;
`endif

   assign setup    = (state_q == S_IDLE) && bus.psel && !bus.penable;
   assign complete = (state_q == S_ACCESS) && bus.psel && (cnt_q == '0);
   assign commit   = complete && bus.penable && pwrite_q && !err_q;

   // State register and wait-state counter
   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: setup enters ACCESS, counter runs down, deselect aborts
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (setup) begin
               state_d = S_ACCESS;
               cnt_d   = CNT_W'(WAIT_STATES);
            end
         end
         S_ACCESS: begin
            if (!bus.psel) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are non-zero only in the completing ACCESS cycle
   always_comb begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = '0;
      if (complete) begin
         bus.pready  = 1'b1;
         bus.pslverr = err_q;
         bus.prdata  = (!pwrite_q && !err_q) ? rd_q : '0;
      end
   end

   // Capture the transfer in setup; reads latch the word here so a preceding write is visible
   always_ff @(posedge pclk) begin
      if (prst) begin
         pwrite_q <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         strb_q   <= '0;
         rd_q     <= '0;
      end else if (setup) begin
         pwrite_q <= bus.pwrite;
         err_q    <= addr_err;
         idx_q    <= IDX_W'(word_a);
         wdata_q  <= bus.pwdata;
         strb_q   <= strb_in;
         rd_q     <= (!bus.pwrite && !addr_err) ? mem_q[IDX_W'(word_a)] : '0;
      end
   end

   // Memory array: write commits at the edge ending the completing cycle
   always_ff @(posedge pclk) begin
      if (prst) begin
         for (int w = 0; w < DEPTH; w++) begin
            mem_q[w] <= '0;
         end
      end else if (commit) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (strb_q[b]) begin
               mem_q[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed vector bench for apb_slave_mem (WAIT_STATES=1 and 0 instances)
module tb_apb_slave_mem;
   logic        pclk = 1'b0;
   logic        prst = 1'b1;
   logic        use0 = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = 4'hF;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 pclk = ~pclk;

   apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
   apb_slave_mem_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();

   assign bus1.psel    = psel & ~use0;
   assign bus1.penable = penable;
   assign bus1.pwrite  = pwrite;
   assign bus1.paddr   = paddr;
   assign bus1.pwdata  = pwdata;
   assign bus0.psel    = psel & use0;
   assign bus0.penable = penable;
   assign bus0.pwrite  = pwrite;
   assign bus0.paddr   = paddr;
   assign bus0.pwdata  = pwdata;
`ifdef APB_SLV_PSTRB_EN
   assign bus1.pstrb   = pstrb;
   assign bus0.pstrb   = pstrb;
`endif

   apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(1)) dut (
      .pclk (pclk),
      .prst (prst),
      .bus  (bus1)
   );

   apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
      .pclk (pclk),
      .prst (prst),
      .bus  (bus0)
   );

   wire        obs_pready  = use0 ? bus0.pready  : bus1.pready;
   wire        obs_pslverr = use0 ? bus0.pslverr : bus1.pslverr;
   wire [31:0] obs_prdata  = use0 ? bus0.prdata  : bus1.prdata;

   typedef struct {
      string       name;
      bit          ws0;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      bit          exp_err;
      int          exp_n;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Caller is just after a rising edge; returns just after the edge that ends the transfer.
   task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, output logic [31:0] rd, output logic err,
                       output int n);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      @(posedge pclk); #1;
      penable = 1'b1;
      n = 0; rd = '0; err = 1'b0;
      forever begin
         @(negedge pclk);
         n++;
         if (obs_pready) begin
            rd = obs_prdata;
            err = obs_pslverr;
            break;
         end
         if (n > 20) begin
            check("xfer_timeout", 32'(n), 32'd0);
            break;
         end
         @(posedge pclk); #1;
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        err;
      int          n;

      vecs[0]  = '{"w_08",       0, 1, 32'h08,        32'hDEADBEEF, 32'h0,        0, 2};
      vecs[1]  = '{"r_08",       0, 0, 32'h08,        32'h0,        32'hDEADBEEF, 0, 2};
      vecs[2]  = '{"r_40_range", 0, 0, 32'h40,        32'h0,        32'h0,        1, 2};
      vecs[3]  = '{"w_05_misal", 0, 1, 32'h05,        32'hAAAAAAAA, 32'h0,        1, 2};
      vecs[4]  = '{"r_04_clean", 0, 0, 32'h04,        32'h0,        32'h0,        0, 2};
      vecs[5]  = '{"r_3c_zero",  0, 0, 32'h3C,        32'h0,        32'h0,        0, 2};
      vecs[6]  = '{"w_3c",       0, 1, 32'h3C,        32'hCAFEF00D, 32'h0,        0, 2};
      vecs[7]  = '{"r_3c",       0, 0, 32'h3C,        32'h0,        32'hCAFEF00D, 0, 2};
      vecs[8]  = '{"r_hi_alias", 0, 0, 32'h10000008,  32'h0,        32'h0,        1, 2};
      vecs[9]  = '{"r_08_again", 0, 0, 32'h08,        32'h0,        32'hDEADBEEF, 0, 2};
      vecs[10] = '{"ws0_w_00",   1, 1, 32'h00,        32'h11,       32'h0,        0, 1};
      vecs[11] = '{"ws0_r_00",   1, 0, 32'h00,        32'h0,        32'h11,       0, 1};
      vecs[12] = '{"ws0_r_02",   1, 0, 32'h02,        32'h0,        32'h0,        1, 1};

      repeat (3) @(posedge pclk);
      #1;
      check("rst_pready1",  32'(bus1.pready),  32'd0);
      check("rst_pslverr1", 32'(bus1.pslverr), 32'd0);
      check("rst_prdata1",  bus1.prdata,       32'd0);
      check("rst_pready0",  32'(bus0.pready),  32'd0);
      check("rst_pslverr0", 32'(bus0.pslverr), 32'd0);
      check("rst_prdata0",  bus0.prdata,       32'd0);
      prst = 1'b0;
      @(posedge pclk); #1;

      for (int i = 0; i < 13; i++) begin
         use0 = vecs[i].ws0;
         xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, 4'hF, rd, err, n);
         check({vecs[i].name, "_prdata"},  rd,          vecs[i].exp_rd);
         check({vecs[i].name, "_pslverr"}, 32'(err),    32'(vecs[i].exp_err));
         check({vecs[i].name, "_cycles"},  32'(n),      32'(vecs[i].exp_n));
      end
      use0 = 1'b0;

      // psel dropped in the first access cycle of a write: no completion, nothing written
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h55;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(negedge pclk);
      check("abort_acc_pready", 32'(obs_pready), 32'd0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("abort_after_pready", 32'(obs_pready), 32'd0);
      @(posedge pclk); #1;
      xfer(1'b0, 32'h0C, 32'h0, 4'hF, rd, err, n);
      check("abort_r_0c", rd, 32'h0);

      // psel&penable while idle is ignored
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h00; pwdata = 32'h99;
      @(negedge pclk);
      check("viol_pready_a", 32'(obs_pready), 32'd0);
      @(posedge pclk); #1;
      @(negedge pclk);
      check("viol_pready_b", 32'(obs_pready), 32'd0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      xfer(1'b0, 32'h00, 32'h0, 4'hF, rd, err, n);
      check("viol_r_00", rd, 32'h0);

`ifdef APB_SLV_PSTRB_EN
      xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, rd, err, n);
      xfer(1'b1, 32'h10, 32'h12345678, 4'b0011, rd, err, n);
      xfer(1'b0, 32'h10, 32'h0, 4'b0000, rd, err, n);
      check("strb_r_10", rd, 32'hFFFF5678);
`endif

      // reset asserted in the access phase of a write aborts it and clears memory
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h77;
      @(posedge pclk); #1;
      penable = 1'b1; prst = 1'b1;
      @(posedge pclk); #1;
      prst = 1'b0; psel = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("rstacc_pready", 32'(obs_pready), 32'd0);
      check("rstacc_prdata", obs_prdata, 32'd0);
      @(posedge pclk); #1;
      xfer(1'b0, 32'h04, 32'h0, 4'hF, rd, err, n);
      check("rstacc_r_04", rd, 32'h0);
      xfer(1'b0, 32'h08, 32'h0, 4'hF, rd, err, n);
      check("rstacc_r_08_cleared", rd, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
